// File: rtl/spike_select_network_pkg.sv
// rtl/spike_select_network_pkg.sv - shared types, constants and helpers for spike_select_network
//
// Package spike_net_pkg:
//   net_state_t    : round FSM states (IDLE, SELECT, OUT)
//   DEF_LFSR_TAPS  : default feedback tap mask (bits 8 and 4)
//   DEF_LFSR_SEED  : default LFSR reset value
//   clamp_bits()   : clamps the active-window width into [1, max_bits]
//   lane_slice()   : bit offset of lane k inside a packed lane bus
package spike_net_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_OUT    = 2'd2
  } net_state_t;

  localparam logic [8:0] DEF_LFSR_TAPS = 9'h110;
  localparam logic [8:0] DEF_LFSR_SEED = 9'h193;

  // A zero-width window would make every ID 0, and widths above the
  // ID register make no sense, so the window is pinned to [1, max_bits].
  function automatic int clamp_bits(input logic [3:0] bits, input int max_bits);
    int b;
    b = int'(bits);
    if (b < 1) begin
      b = 1;
    end else if (b > max_bits) begin
      b = max_bits;
    end
    return b;
  endfunction

  function automatic int lane_slice(input int lane, input int lane_width);
    return lane * lane_width;
  endfunction

endpackage

// File: rtl/spike_select_network_lfsr_multi_step.sv
// rtl/spike_select_network_lfsr_multi_step.sv - combinational chain of LFSR steps
//
// Module lfsr_multi_step:
//   state       : in,  WIDTH        current LFSR state
//   taps        : in,  WIDTH        feedback tap mask (XOR of masked bits)
//   next_states : out, STEPS*WIDTH  slice k = state after k+1 chained steps
module lfsr_multi_step #(
  parameter int WIDTH = 9,
  parameter int STEPS = 2
) (
  input  logic [WIDTH-1:0]       state,
  input  logic [WIDTH-1:0]       taps,
  output logic [STEPS*WIDTH-1:0] next_states
);

  logic [WIDTH-1:0] walk;

  always_comb begin
    walk        = state;
    next_states = '0;
    for (int k = 0; k < STEPS; k++) begin
      walk = {walk[WIDTH-2:0], ^(walk & taps)};
      next_states[k*WIDTH +: WIDTH] = walk;
    end
  end

endmodule

// File: rtl/spike_select_network.sv
// rtl/spike_select_network.sv - pseudo-random multi-lane spike selector
//
// Captures the spike vector on a round request, picks NUM_OUT neuron IDs
// from an LFSR masked to the active window and presents the
// (spike value, neuron ID) pairs downstream with a valid/ready handshake.
// Optional build macro: SPIKE_SKIP_ZERO_EN (drop rounds whose lanes are all zero,
// lane_valid flags non-zero lanes).
//
// Ports:
//   clk, reset_l            : clock, asynchronous active-low reset
//   en_network              : round start request (seen in IDLE only)
//   top_en_network          : global stall enable, low freezes all state
//   spike_in                : NUM_NEURON x TEN_DATA_WIDTH spike vector
//   bits_in_active_neuron   : active ID window width
//   out_ready               : downstream accepts the round
//   out_valid, lane_valid   : round / per-lane qualifiers
//   spike_out               : lane k = {spike value, neuron ID}
//   network_done            : one-cycle pulse when a round completes
module spike_select_network
  import spike_net_pkg::*;
#(
  parameter int                         TEN_DATA_WIDTH  = 2,
  parameter int                         NUM_NEURON      = 512,
  parameter int                         NEURON_ID_WIDTH = 9,
  parameter int                         NUM_OUT         = 2,
  parameter logic [NEURON_ID_WIDTH-1:0] LFSR_TAPS       = DEF_LFSR_TAPS,
  parameter logic [NEURON_ID_WIDTH-1:0] LFSR_SEED       = DEF_LFSR_SEED
) (
  input  logic                                                clk,
  input  logic                                                reset_l,
  input  logic                                                en_network,
  input  logic                                                top_en_network,
  input  logic [TEN_DATA_WIDTH*NUM_NEURON-1:0]                spike_in,
  input  logic [3:0]                                          bits_in_active_neuron,
  input  logic                                                out_ready,
  output logic                                                out_valid,
  output logic [NUM_OUT-1:0]                                  lane_valid,
  output logic [NUM_OUT*(TEN_DATA_WIDTH+NEURON_ID_WIDTH)-1:0] spike_out,
  output logic                                                network_done
);

  localparam int TW = TEN_DATA_WIDTH;
  localparam int IW = NEURON_ID_WIDTH;
  localparam int LW = TW + IW;
  localparam int CW = $clog2(TW * NUM_NEURON);

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [IW-1:0] SEED_EFF =
    (LFSR_SEED == '0) ? {{(IW-1){1'b0}}, 1'b1} : LFSR_SEED;

  net_state_t                 state;
  logic [IW-1:0]              lfsr;
  logic [TW*NUM_NEURON-1:0]   cap;
  logic [IW-1:0]              ids [NUM_OUT];
  logic [NUM_OUT*IW-1:0]      steps;
  logic [IW-1:0]              id_mask;
  logic [CW-1:0]              sel_base [NUM_OUT];
  logic [TW-1:0]              lane_spike [NUM_OUT];

  lfsr_multi_step #(
    .WIDTH (IW),
    .STEPS (NUM_OUT)
  ) u_lfsr_steps (
    .state       (lfsr),
    .taps        (LFSR_TAPS),
    .next_states (steps)
  );

  always_comb begin
    id_mask = '0;
    for (int i = 0; i < IW; i++) begin
      if (i < clamp_bits(bits_in_active_neuron, IW)) begin
        id_mask[i] = 1'b1;
      end
    end
  end

  // Spike lookup from the captured vector; IDs past the neuron array read 0.
  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) begin
      sel_base[k]   = '0;
      lane_spike[k] = '0;
      if (int'(ids[k]) < NUM_NEURON) begin
        sel_base[k]   = CW'(int'(ids[k]) * TW);
        lane_spike[k] = cap[sel_base[k] +: TW];
      end
    end
  end

`ifdef SPIKE_SKIP_ZERO_EN
  logic [NUM_OUT-1:0] lane_nz;

  always_comb begin
    lane_nz = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      lane_nz[k] = |lane_spike[k];
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state        <= ST_IDLE;
      lfsr         <= SEED_EFF;
      cap          <= '0;
      out_valid    <= 1'b0;
      lane_valid   <= '0;
      spike_out    <= '0;
      network_done <= 1'b0;
      for (int k = 0; k < NUM_OUT; k++) begin
        ids[k] <= '0;
      end
    end else if (!top_en_network) begin
      // Stalled: everything holds, and the done pulse is not stretched.
      network_done <= 1'b0;
    end else begin
      network_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en_network) begin
            cap  <= spike_in;
            lfsr <= steps[(NUM_OUT-1)*IW +: IW];
            for (int k = 0; k < NUM_OUT; k++) begin
              ids[k] <= steps[k*IW +: IW] & id_mask;
            end
            state <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          for (int k = 0; k < NUM_OUT; k++) begin
            spike_out[lane_slice(k, LW) +: LW] <= {lane_spike[k], ids[k]};
          end
`ifdef SPIKE_SKIP_ZERO_EN
          if (|lane_nz) begin
            out_valid  <= 1'b1;
            lane_valid <= lane_nz;
            state      <= ST_OUT;
          end else begin
            network_done <= 1'b1;
            state        <= ST_IDLE;
          end
`else
          out_valid  <= 1'b1;
          lane_valid <= '1;
          state      <= ST_OUT;
`endif
        end
        ST_OUT: begin
          if (out_valid && out_ready) begin
            out_valid    <= 1'b0;
            lane_valid   <= '0;
            network_done <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_select_network.sv
// tb/tb_spike_select_network.sv - self-checking bench for spike_select_network
module tb_spike_select_network;

  localparam int NN  = 512;
  localparam int NO  = 2;
  localparam int LWB = 11;

  logic            clk;
  logic            reset_l;
  logic            en_network;
  logic            top_en_network;
  logic [2*NN-1:0] spike_in;
  logic [3:0]      bits_in_active_neuron;
  logic            out_ready;
  logic            out_valid;
  logic [NO-1:0]   lane_valid;
  logic [NO*LWB-1:0] spike_out;
  logic            network_done;

  int n_chk  = 0;
  int n_pass = 0;
  bit started = 0;

  spike_select_network dut (
    .clk                   (clk),
    .reset_l               (reset_l),
    .en_network            (en_network),
    .top_en_network        (top_en_network),
    .spike_in              (spike_in),
    .bits_in_active_neuron (bits_in_active_neuron),
    .out_ready             (out_ready),
    .out_valid             (out_valid),
    .lane_valid            (lane_valid),
    .spike_out             (spike_out),
    .network_done          (network_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int          m_lfsr;
  logic        m_pend, m_valid, m_done;
  logic [NO-1:0]     m_lv;
  logic [NO*LWB-1:0] m_so;
  int          m_id  [NO];
  int          m_val [NO];

  function automatic int lfsr_next(input int s);
    int fb;
    fb = $countones(s & 'h110) & 1;
    return ((s << 1) & 'h1FF) | fb;
  endfunction

  function automatic int window(input int bits);
    int b;
    b = (bits < 1) ? 1 : ((bits > 9) ? 9 : bits);
    return (1 << b) - 1;
  endfunction

  always @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      m_lfsr = 'h193; m_pend = 0; m_valid = 0; m_done = 0; m_lv = '0; m_so = '0;
    end else if (!top_en_network) begin
      m_done = 0;
    end else begin
      m_done = 0;
      if (m_valid) begin
        if (out_ready) begin
          m_valid = 0; m_lv = '0; m_done = 1;
        end
      end else if (m_pend) begin
        m_pend = 0;
        for (int k = 0; k < NO; k++)
          m_so[k*LWB +: LWB] = {2'(m_val[k]), 9'(m_id[k])};
`ifdef SPIKE_SKIP_ZERO_EN
        if (m_val[0] == 0 && m_val[1] == 0) begin
          m_done = 1;
        end else begin
          m_valid = 1;
          for (int k = 0; k < NO; k++) m_lv[k] = (m_val[k] != 0);
        end
`else
        m_valid = 1; m_lv = '1;
`endif
      end else if (en_network) begin
        for (int k = 0; k < NO; k++) begin
          m_lfsr   = lfsr_next(m_lfsr);
          m_id[k]  = m_lfsr & window(int'(bits_in_active_neuron));
          m_val[k] = (m_id[k] < NN) ? int'(spike_in[m_id[k]*2 +: 2]) : 0;
        end
        m_pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("cmp_out_valid", out_valid, m_valid);
      check("cmp_lane_valid", lane_valid, m_lv);
      check("cmp_network_done", network_done, m_done);
      check("cmp_spike_out", spike_out, m_so);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic apply_reset();
    @(posedge clk); #2 reset_l = 1'b0;
    @(negedge clk); reset_l = 1'b1;
  endtask

  task automatic do_round(input logic [3:0] b, input int id0, input int id1, input string tag);
    bits_in_active_neuron = b;
    out_ready  = 1'b1;
    en_network = 1'b1;
    @(negedge clk); en_network = 1'b0;
    check({tag, "_lat1_valid"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_lat2_valid"}, out_valid, 1);
    check({tag, "_id0"}, spike_out[8:0], id0);
    check({tag, "_id1"}, spike_out[LWB+8:LWB], id1);
    @(negedge clk);
    check({tag, "_done"}, network_done, 1);
    check({tag, "_valid_drop"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_done_clear"}, network_done, 0);
  endtask

  logic [NO*LWB-1:0] held;
  int dones;

  initial begin
    reset_l = 1'b0; en_network = 1'b0; top_en_network = 1'b1;
    spike_in = '1; bits_in_active_neuron = 4'd9; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_lane_valid", lane_valid, 0);
    check("rst_done", network_done, 0);
    check("rst_spike_out", spike_out, 0);
    reset_l = 1'b1;
    started = 1;

    do_round(4'd9, 294, 77, "b9");
    check("model_lfsr_after_round", m_lfsr, 'h04D);
    apply_reset(); do_round(4'd4, 6, 13, "b4");
    apply_reset(); do_round(4'd0, 0, 1, "b0");
    apply_reset(); do_round(4'd15, 294, 77, "b15");

    // capture isolation: spike_in changes after capture must not leak
    apply_reset();
    spike_in = '0;
    spike_in[294*2 +: 2] = 2'b10;
    spike_in[77*2 +: 2]  = 2'b01;
    bits_in_active_neuron = 4'd9;
    en_network = 1'b1;
    @(negedge clk); en_network = 1'b0; spike_in = '1;
    @(negedge clk);
    check("cap_lane0", spike_out[LWB-1:0], {2'b10, 9'd294});
    check("cap_lane1", spike_out[2*LWB-1:LWB], {2'b01, 9'd77});
    @(negedge clk);
    @(negedge clk);

    // backpressure: outputs hold, en_network ignored, single done
    out_ready = 1'b0; en_network = 1'b1;
    @(negedge clk); en_network = 1'b0;
    @(negedge clk);
    check("bp_valid", out_valid, 1);
    held = spike_out; dones = 0;
    for (int i = 0; i < 5; i++) begin
      en_network = (i % 2 == 0);
      @(negedge clk);
      check("bp_hold_data", spike_out, held);
      check("bp_hold_valid", out_valid, 1);
      if (network_done) dones++;
    end
    en_network = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    if (network_done) dones++;
    check("bp_done_count", dones, 1);
    @(negedge clk);
    check("bp_done_clear", network_done, 0);

    // stall 3 cycles in IDLE, SELECT and OUT
    en_network = 1'b1; top_en_network = 1'b0;
    repeat (3) @(negedge clk);
    top_en_network = 1'b1;
    @(negedge clk);
    en_network = 1'b0; top_en_network = 1'b0;
    repeat (3) @(negedge clk);
    check("stall_sel_valid", out_valid, 0);
    top_en_network = 1'b1;
    @(negedge clk);
    check("stall_valid_up", out_valid, 1);
    top_en_network = 1'b0;
    repeat (3) @(negedge clk);
    check("stall_out_valid", out_valid, 1);
    check("stall_out_nodone", network_done, 0);
    top_en_network = 1'b1;
    @(negedge clk);
    check("stall_done", network_done, 1);
    @(negedge clk);

    // reset mid-OUT aborts the round and reseeds the LFSR
    out_ready = 1'b0; en_network = 1'b1;
    @(negedge clk); en_network = 1'b0;
    @(negedge clk);
    check("abort_pre_valid", out_valid, 1);
    @(posedge clk); #2 reset_l = 1'b0;
    #1;
    check("abort_async_valid", out_valid, 0);
    check("abort_no_done", network_done, 0);
    @(negedge clk); reset_l = 1'b1;
    do_round(4'd9, 294, 77, "reseed");

`ifdef SPIKE_SKIP_ZERO_EN
    apply_reset();
    spike_in = '0; out_ready = 1'b1;
    en_network = 1'b1;
    @(negedge clk); en_network = 1'b0;
    @(negedge clk);
    check("skip_done", network_done, 1);
    check("skip_no_valid", out_valid, 0);
    @(negedge clk);
    check("skip_done_clear", network_done, 0);
    check("skip_still_idle", out_valid, 0);
`endif

    repeat (2) @(negedge clk);
    started = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
